step_unified_chain: RTL
=======================

Name: step_unified_chain

Overview:
- Parametrised successor to the two-stage FIOS inner-loop step for half of an Fp^2 Montgomery multiplication.
- Computes S = a0*a1 +/- b0*b1 + c0*c1 + d + C per beat. The add/sub mode is selected per beat.
- The j-loop carry is chained internally between beats, so the outer controller no longer feeds carry back.
- Multiplier latency is configurable, and valid/first/last tags travel with each beat through the pipeline.

Parameters:
- RADIX, 32, word width w; must be >= 4.
- MUL_LAT, 1, register stages in each product path; must be >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- in_valid  in  1  issue strobe: operands a_0..c_1 and tags valid this cycle (cycle k).
- in_mode  in  1  0 = add (a+b+c), 1 = sub (a-b+c).
- in_first  in  1  beat is j=0; carry term forced to 0.
- in_last  in  1  beat is final j of the row.
- a_0, a_1, b_0, b_1, c_0, c_1  in  RADIX each  multiplier operands, cycle k.
- d  in  RADIX  t[j] word, presented at cycle k+MUL_LAT.
- d_last  in  1  d is the top (signed) word, presented at cycle k+MUL_LAT.
- out_valid  out  1  sum/carry_out valid, cycle k+MUL_LAT+1.
- out_last  out  1  delayed in_last.
- sum  out  RADIX  low word of result (t[j-1]).
- carry_out  out  RADIX+2  current chained carry.

Behaviour:
- Pipeline
  - Three products per beat, each with MUL_LAT register stages.
  - valid, mode, first and last travel in a MUL_LAT-deep tag shift register aligned with the products.
- Sum stage (cycle k+MUL_LAT), width 2*RADIX+2: X = P_a + P_c + (mode ? -P_b : +P_b) + D + Cx.
  - Products are zero-extended.
  - D: sign-extended only when mode=1 and d_last=1; otherwise zero-extended.
  - Cx: 0 if tagged first=1. Otherwise it is the internal carry register:
    - mode=1: sign-extended (signed RADIX+2).
    - mode=0: zero-extended (unsigned RADIX+2; max add carry < 4*2^RADIX).
- Register update on tagged valid=1 at the sum stage: sum <= X[RADIX-1:0]; carry register <= X[2*RADIX+1:RADIX]; out_valid <= 1; out_last <= tagged last.
- Register update on tagged valid=0: out_valid <= 0; sum, carry and out_last hold.
  - Bubbles between beats therefore do not break the carry chain.
- Back-to-back beats (in_valid high on consecutive cycles): beat n+1 sees beat n's registered carry; full throughput, one beat per cycle.
- A first=1 beat restarts the chain regardless of any prior carry. No other reset of the carry between rows is needed.
- Mode may change per beat. The carry extension rule uses the consuming beat's mode.
- d and d_last are ignored on cycles with no tagged valid beat at the sum stage.
- Latency in_valid -> out_valid: MUL_LAT+1 cycles.
- Reset values: out_valid=0, out_last=0, sum=0, carry_out=0, all tag and product registers 0.
  - Reset mid-operation discards in-flight beats; no out_valid pulse follows release for beats issued before reset.
- Overflow: none in the sum stage for legal FIOS operands. Bits above 2*RADIX+1 are truncated.

Test Plan:
- RADIX=8, MUL_LAT=1, add mode, first=1: a=b=c=0xFF*0xFF, d=0xFF at k+1 -> out_valid at k+2, sum=0x02, carry_out=0x2FB.
- Same beat followed next cycle by an add beat with all operands 0, first=0, d=0 -> sum=0xFB, carry_out=0x002 (back-to-back chaining).
- Sub mode, first=1: a_0=a_1=1, b_0=b_1=0x10, c=0, d=0 -> sum=0x01, carry_out=0x3FF. Next sub beat with zeros, first=0 -> sum=0xFF, carry_out=0x3FF (signed carry propagation).
- Sub mode, first=1, d=0x80, d_last=1, products 0 -> sum=0x80, carry_out=0x3FF. With d_last=0 -> carry_out=0x000.
- Bubbles and latency:
  - MUL_LAT=3: issue add beat (a=2*3, others 0, first=1), wait 4 idle cycles, then issue add zeros first=0 -> sum=0x06 then sum=0x00, carry held 0.
  - out_valid exactly 4 cycles after each issue; out_last follows in_last.
- Assert rst asynchronously between issue and output -> out_valid, sum and carry_out drop to 0 immediately; no output pulse after release.

Source files
------------

// File: rtl/step_unified_chain.sv
// FIOS inner-loop step for half of an Fp^2 Montgomery product: S = a0*a1 +/- b0*b1 + c0*c1 + d + carry,
// with configurable multiplier latency and the j-loop carry chained internally between beats.
module step_unified_chain #(
  parameter int RADIX   = 32,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_mode,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [RADIX-1:0]   a_0,
  input  logic [RADIX-1:0]   a_1,
  input  logic [RADIX-1:0]   b_0,
  input  logic [RADIX-1:0]   b_1,
  input  logic [RADIX-1:0]   c_0,
  input  logic [RADIX-1:0]   c_1,
  input  logic [RADIX-1:0]   d,
  input  logic               d_last,
  output logic               out_valid,
  output logic               out_last,
  output logic [RADIX-1:0]   sum,
  output logic [RADIX+1:0]   carry_out
);

  localparam int PW = 2 * RADIX;
  localparam int XW = 2 * RADIX + 2;
  localparam int CW = RADIX + 2;

  logic [PW-1:0]      r_pa [MUL_LAT];
  logic [PW-1:0]      r_pb [MUL_LAT];
  logic [PW-1:0]      r_pc [MUL_LAT];
  logic [MUL_LAT-1:0] r_tv;
  logic [MUL_LAT-1:0] r_tm;
  logic [MUL_LAT-1:0] r_tf;
  logic [MUL_LAT-1:0] r_tl;

  logic [RADIX-1:0]   r_sum;
  logic [CW-1:0]      r_carry;
  logic               r_ov;
  logic               r_ol;

  logic [PW-1:0] w_mul_a;
  logic [PW-1:0] w_mul_b;
  logic [PW-1:0] w_mul_c;
  logic [XW-1:0] w_pa_x;
  logic [XW-1:0] w_pb_x;
  logic [XW-1:0] w_pc_x;
  logic [XW-1:0] w_pb_s;
  logic [XW-1:0] w_d_x;
  logic [XW-1:0] w_c_x;
  logic [XW-1:0] w_x;
  logic          w_mode;

  assign w_mul_a = PW'(a_0) * PW'(a_1);
  assign w_mul_b = PW'(b_0) * PW'(b_1);
  assign w_mul_c = PW'(c_0) * PW'(c_1);

  // Products and tags advance every cycle; only the tagged valid bit decides what the sum stage does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
        r_pc[i] <= '0;
      end
      r_tv <= '0;
      r_tm <= '0;
      r_tf <= '0;
      r_tl <= '0;
    end else begin
      r_pa[0] <= w_mul_a;
      r_pb[0] <= w_mul_b;
      r_pc[0] <= w_mul_c;
      r_tv[0] <= in_valid;
      r_tm[0] <= in_mode;
      r_tf[0] <= in_first;
      r_tl[0] <= in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
        r_pc[i] <= r_pc[i-1];
        r_tv[i] <= r_tv[i-1];
        r_tm[i] <= r_tm[i-1];
        r_tf[i] <= r_tf[i-1];
        r_tl[i] <= r_tl[i-1];
      end
    end
  end

  assign w_mode = r_tm[MUL_LAT-1];
  assign w_pa_x = XW'(r_pa[MUL_LAT-1]);
  assign w_pb_x = XW'(r_pb[MUL_LAT-1]);
  assign w_pc_x = XW'(r_pc[MUL_LAT-1]);
  assign w_pb_s = w_mode ? (XW'(0) - w_pb_x) : w_pb_x;

  // Only the top word of a subtraction row is signed.
  assign w_d_x = (w_mode && d_last) ? {{(XW-RADIX){d[RADIX-1]}}, d} : XW'(d);

  // The consuming beat's mode decides how the previous carry is extended.
  assign w_c_x = r_tf[MUL_LAT-1] ? '0 :
                 w_mode          ? {{(XW-CW){r_carry[CW-1]}}, r_carry} : XW'(r_carry);

  assign w_x = w_pa_x + w_pc_x + w_pb_s + w_d_x + w_c_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_ov    <= 1'b0;
      r_ol    <= 1'b0;
    end else if (r_tv[MUL_LAT-1]) begin
      r_sum   <= w_x[RADIX-1:0];
      r_carry <= w_x[XW-1:RADIX];
      r_ov    <= 1'b1;
      r_ol    <= r_tl[MUL_LAT-1];
    end else begin
      r_ov    <= 1'b0;
    end
  end

  assign out_valid = r_ov;
  assign out_last  = r_ol;
  assign sum       = r_sum;
  assign carry_out = r_carry;

endmodule
